// File: rtl/sd_envelope_detect_if.sv
// sd_envelope_detect_if: bus carrying magnitude input, thresholds/hold config and envelope/presence outputs
interface sd_envelope_detect_if #(
  parameter int WIDTH     = 16,
  parameter int HOLD_BITS = 12
);
  logic                 en;
  logic [WIDTH-1:0]     mag;
  logic [WIDTH-1:0]     threshOn;
  logic [WIDTH-1:0]     threshOff;
  logic [HOLD_BITS-1:0] holdCycles;
  logic [WIDTH-1:0]     peak;
  logic                 active;
  logic                 rise;
  logic                 fall;
  modport master (output en, mag, threshOn, threshOff, holdCycles, input peak, active, rise, fall);
  modport slave  (input en, mag, threshOn, threshOff, holdCycles, output peak, active, rise, fall);
endinterface

// File: rtl/sd_envelope_detect.sv
// sd_envelope_detect: instant-attack/exponential-decay envelope with qualify/hold carrier-detect FSM (ports: clk, rst, bus.slave)
module sd_envelope_detect #(
  parameter int WIDTH       = 16,
  parameter int DECAY_SHIFT = 8,
  parameter int QUAL        = 4,
  parameter int HOLD_BITS   = 12
) (
  input logic                  clk,
  input logic                  rst,
  sd_envelope_detect_if.slave  bus
);
  localparam int CW = $clog2(QUAL);
  typedef enum logic [1:0] {IDLE, ARM, ACT, HOLD} state_t;
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [HOLD_BITS-1:0] hcnt_q, hcnt_d;
  logic [WIDTH-1:0]     peak_q, peak_d, decay;
  logic                 active_q, active_d, rise_q, rise_d, fall_q, fall_d;
  always_comb begin
    decay  = peak_q >> DECAY_SHIFT;
    // small peaks whose shifted decay is zero still bleed down by one per cycle
    peak_d = !bus.en                ? peak_q :
             bus.mag >= peak_q      ? bus.mag :
             decay != '0            ? peak_q - decay :
             peak_q != '0           ? peak_q - 1'b1 : peak_q;
  end
  // FSM looks at the registered peak, so it lags the envelope by one enabled cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hcnt_d  = hcnt_q;
    if (bus.en)
      case (state_q)
        IDLE: if (peak_q >= bus.threshOn) begin
          state_d = ARM;
          cnt_d   = CW'(1);
        end
        ARM: if (peak_q < bus.threshOn) state_d = IDLE;
          else if (cnt_q == CW'(QUAL - 1)) state_d = ACT;
          else cnt_d = cnt_q + 1'b1;
        ACT: if (peak_q < bus.threshOff) begin
          state_d = HOLD;
          hcnt_d  = bus.holdCycles;
        end
        HOLD: if (peak_q >= bus.threshOff) state_d = ACT;
          else if (hcnt_q == '0) state_d = IDLE;
          else hcnt_d = hcnt_q - 1'b1;
      endcase
  end
  always_comb begin
    active_d = state_d == ACT || state_d == HOLD;
    rise_d   = state_q == ARM && state_d == ACT;
    fall_d   = state_q == HOLD && state_d == IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      peak_q   <= '0;
      active_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      peak_q   <= peak_d;
      active_q <= active_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end
  assign bus.peak   = peak_q;
  assign bus.active = active_q;
  assign bus.rise   = rise_q;
  assign bus.fall   = fall_q;
endmodule

// File: tb/tb_sd_envelope_detect.sv
// tb_sd_envelope_detect: directed plus randomized checks of sd_envelope_detect against a run-length reference model
module tb_sd_envelope_detect;
  localparam int WIDTH = 16, DECAY_SHIFT = 4, QUAL = 4, HOLD_BITS = 12;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0, checks = 0;
  int th_on = 500, th_off = 400, hold_cfg = 10;
  int m_peak, run_on, low_run, hold_lat;
  bit m_act, m_rise, m_fall;
  sd_envelope_detect_if #(.WIDTH(WIDTH), .HOLD_BITS(HOLD_BITS)) bus ();
  sd_envelope_detect #(.WIDTH(WIDTH), .DECAY_SHIFT(DECAY_SHIFT), .QUAL(QUAL), .HOLD_BITS(HOLD_BITS))
    dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(string tag, int got, int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic cfg(int on, int off, int h);
    th_on = on; th_off = off; hold_cfg = h;
    bus.threshOn = on[15:0]; bus.threshOff = off[15:0]; bus.holdCycles = h[11:0];
  endtask
  // presence modelled as run lengths: QUAL consecutive high peaks to assert,
  // hold+2 consecutive low peaks (entry edge, hold countdown, release edge) to drop
  task automatic model_edge(bit r, bit e, int mg);
    int d;
    m_rise = 0; m_fall = 0;
    if (r) begin
      m_peak = 0; m_act = 0; run_on = 0; low_run = 0;
      return;
    end
    if (!e) return;
    if (!m_act) begin
      run_on = (m_peak >= th_on) ? run_on + 1 : 0;
      if (run_on == QUAL) begin m_act = 1; m_rise = 1; run_on = 0; end
    end else if (m_peak < th_off) begin
      if (low_run == 0) hold_lat = hold_cfg;
      low_run++;
      if (low_run == hold_lat + 2) begin m_act = 0; m_fall = 1; low_run = 0; end
    end else low_run = 0;
    d = m_peak / (1 << DECAY_SHIFT);
    m_peak = (mg >= m_peak) ? mg : (d != 0) ? m_peak - d : (m_peak != 0) ? m_peak - 1 : 0;
  endtask
  task automatic step(bit r, bit e, int mg);
    rst = r; bus.en = e; bus.mag = mg[15:0];
    @(posedge clk);
    model_edge(r, e, mg);
    #1;
    chk("peak", int'(bus.peak), m_peak);
    chk("active", int'(bus.active), int'(m_act));
    chk("rise", int'(bus.rise), int'(m_rise));
    chk("fall", int'(bus.fall), int'(m_fall));
  endtask
  initial begin
    int gap, n, saved, cur;
    bit seen, got;
    bus.en = 1'b1; bus.mag = '0;
    cfg(500, 400, 10);
    m_peak = 0; m_act = 0; run_on = 0; low_run = 0; hold_lat = 0;
    for (int i = 0; i < 3; i++) step(1, 1, 1000);
    chk("rst_peak", int'(bus.peak), 0);
    chk("rst_active", int'(bus.active), 0);
    step(0, 1, 1000);
    chk("post_rst_peak", int'(bus.peak), 1000);
    step(1, 1, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 1, 1000);
    chk("qual_peak", int'(bus.peak), 1000);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1000);
      chk("qual_wait_active", int'(bus.active), 0);
    end
    step(0, 1, 1000);
    chk("qual_active", int'(bus.active), 1);
    chk("qual_rise", int'(bus.rise), 1);
    step(0, 1, 1000);
    chk("qual_rise_clear", int'(bus.rise), 0);
    seen = 0; got = 0; gap = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      if (!seen && m_peak < 400) begin seen = 1; gap = 0; end
      if (seen) gap++;
      step(0, 1, 0);
      got = bus.fall;
    end
    chk("fall_seen", int'(got), 1);
    chk("hold_len", gap, 12);
    chk("fall_inactive", int'(bus.active), 0);
    step(1, 1, 0);
    step(0, 1, 5);
    for (int i = 0; i < 4; i++) step(0, 1, 0);
    chk("tail_4", int'(bus.peak), 1);
    step(0, 1, 0);
    chk("tail_5", int'(bus.peak), 0);
    step(1, 1, 0);
    cfg(950, 400, 10);
    step(0, 1, 0);
    step(0, 1, 1000);
    chk("glitch_p0", int'(bus.peak), 1000);
    step(0, 1, 0);
    chk("glitch_p1", int'(bus.peak), 938);
    step(0, 1, 0);
    chk("glitch_p2", int'(bus.peak), 880);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0);
      chk("glitch_no_rise", int'(bus.rise), 0);
    end
    chk("glitch_inactive", int'(bus.active), 0);
    step(1, 1, 0);
    cfg(500, 400, 10);
    for (int i = 0; i < 6; i++) step(0, 1, 1000);
    chk("retrig_active", int'(bus.active), 1);
    for (int i = 0; i < 200 && low_run != 6; i++) step(0, 1, 0);
    chk("retrig_in_hold", low_run, 6);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1000);
      chk("retrig_keep", int'(bus.active), 1);
      chk("retrig_no_fall", int'(bus.fall), 0);
      chk("retrig_no_rise", int'(bus.rise), 0);
    end
    for (int i = 0; i < 200 && low_run != 3; i++) step(0, 1, 0);
    saved = m_peak;
    for (int i = 0; i < 20; i++) step(0, 0, int'($urandom_range(0, 4000)));
    chk("freeze_peak", int'(bus.peak), saved);
    chk("freeze_active", int'(bus.active), 1);
    n = 0; got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      step(0, 1, 0);
      n++;
      got = bus.fall;
    end
    chk("resume_len", n, 9);
    for (int i = 0; i < 6; i++) step(0, 1, 1000);
    for (int i = 0; i < 200 && low_run != 4; i++) step(0, 1, 0);
    step(1, 1, 0);
    chk("midrst_active", int'(bus.active), 0);
    chk("midrst_fall", int'(bus.fall), 0);
    step(0, 1, 0);
    chk("midrst_fall_after", int'(bus.fall), 0);
    cur = 0;
    for (int s = 0; s < 8; s++) begin
      cfg(int'($urandom_range(200, 3000)), int'($urandom_range(100, 3000)), int'($urandom_range(0, 20)));
      for (int i = 0; i < 250; i++) begin
        if ($urandom_range(0, 15) == 0) cur = $urandom_range(0, 1) ? int'($urandom_range(0, 4000)) : 0;
        step($urandom_range(0, 299) == 0, $urandom_range(0, 7) != 0, cur);
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sd_envelope_detect.md
Name: sd_envelope_detect

Overview:
- Consumes the unsigned magnitude word produced by the sigma-delta magnitude stage.
- Tracks its envelope with instant attack and exponential decay.
- Runs a qualify/hold state machine with hysteresis that flags signal presence (carrier detect / squelch).
- Sits directly downstream of the magnitude stage, on the same clock and enable.

Parameters:
- WIDTH, 16: width of magnitude input, thresholds and peak output.
- DECAY_SHIFT, 8: envelope decay per enabled cycle is peak >> DECAY_SHIFT.
- QUAL, 4: consecutive enabled cycles with peak >= threshOn required before asserting active; QUAL >= 2.
- HOLD_BITS, 12: width of the hold-time input.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset, synchronous, active-high.
- en, input, 1: clock enable. All state advances only on clk edges with en=1.
- mag, input, WIDTH: unsigned magnitude from the upstream stage.
- threshOn, input, WIDTH: assert threshold.
- threshOff, input, WIDTH: release threshold.
- holdCycles, input, HOLD_BITS: extra enabled cycles active is held after peak falls below threshOff.
- peak, output, WIDTH: envelope value, registered.
- active, output, 1: signal-present flag, registered.
- rise, output, 1: one-clk pulse when active goes 0 to 1.
- fall, output, 1: one-clk pulse when active goes 1 to 0.

Behaviour:
- Reset (rst=1 at a clk edge, regardless of en):
  - peak=0, state IDLE, counters=0, active=0, rise=0, fall=0.
  - Reset mid-operation aborts silently; no fall pulse is generated.
- Envelope update, on each en edge, in priority order:
  - If mag >= peak: peak <= mag.
  - Else if (peak >> DECAY_SHIFT) != 0: peak <= peak - (peak >> DECAY_SHIFT).
  - Else if peak != 0: peak <= peak - 1.
  - Otherwise peak stays at 0.
  - No overflow or underflow is possible.
- FSM timing:
  - Evaluated on en edges, using the registered peak value from before that edge.
  - Result: one cycle of latency from peak to FSM.
  - All comparisons are unsigned.
- IDLE (active=0):
  - peak >= threshOn: go to ARM, cnt <= 1.
- ARM (active=0):
  - peak < threshOn: return to IDLE.
  - Else if cnt == QUAL-1: go to ACTIVE, active <= 1, rise pulse.
  - Else cnt <= cnt + 1.
- ACTIVE (active=1):
  - peak < threshOff: go to HOLD, hcnt <= holdCycles.
- HOLD (active=1):
  - peak >= threshOff: return to ACTIVE, no pulses.
  - Else if hcnt == 0: go to IDLE, active <= 0, fall pulse.
  - Else hcnt <= hcnt - 1.
  - Result: HOLD lasts holdCycles+1 enabled cycles when the signal stays low.
  - holdCycles is sampled only on entry to HOLD.
- Pulse outputs:
  - rise and fall are registered.
  - They are high for exactly one clk after the transitioning edge, then cleared on the next clk even if en=0.
- en=0 freezes peak, state and counters.
- Misconfiguration threshOff > threshOn is legal; behaviour follows the rules above literally.
- Overall latency: mag step to active rise is QUAL+1 enabled cycles.

Test Plan:
Common settings: WIDTH=16, DECAY_SHIFT=4, QUAL=4, en=1 unless stated.
- Reset check: hold rst 3 clks with mag=1000.
  - All outputs must be 0.
  - On release, peak=1000 after the first edge.
- Qualification: threshOn=500, threshOff=400, mag steps 0 to 1000 at edge n.
  - peak=1000 at n.
  - active=1 and rise=1 after edge n+4; rise=0 at n+5.
- Glitch rejection: threshOn=950, mag=1000 for one cycle, then 0.
  - peak goes 1000, 938, 880.
  - FSM enters ARM at n+1 and returns to IDLE at n+2.
  - No rise; active stays 0.
- Hold/release: from ACTIVE with threshOff=400, holdCycles=10, mag=0.
  - peak decays below 400.
  - active stays 1 for 11 enabled cycles in HOLD, then falls with a one-clk fall pulse.
  - Decay tail check: peak=5 reaches 0 in exactly 5 cycles.
- Re-trigger: in HOLD with hcnt=5, drive mag=1000.
  - Return to ACTIVE.
  - No fall and no rise pulse; active never drops.
- Enable gating and mid-reset:
  - en=0 for 20 clks during HOLD: peak, state and hcnt unchanged.
  - rst during HOLD: active=0 next edge, fall stays 0.
